// File: rtl/branch_resolve_unit_pkg.sv
// Types and helpers for the branch resolve unit: FSM states, bus structs,
// and the sequential-PC helper.
`include "global_defines.vh"

package branch_resolve_unit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DS  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    typedef struct packed {
        logic        is_taken;
        logic [1:0]  count;
        logic        valid;
        logic [31:0] ret_addr;
    } bpu_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  old_count;
        logic        is_branch;
        logic        taken;
        logic [31:0] target;
    } bresult_t;

    localparam logic [1:0] CNT_DEFAULT = `CNT_WN_TAKEN;

    function automatic logic [31:0] pc_plus(input logic [31:0] pc, input logic [31:0] ofs);
        return pc + ofs;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX/decode-side inputs and predictor/fetch-side outputs of the branch
// resolve unit; master drives the EX/decode view, slave is the unit itself.
`include "global_defines.vh"

interface branch_resolve_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic                          es_go;
    logic [31:0]                   es_pc;
    logic                          es_is_branch;
    logic                          es_br_taken;
    logic [31:0]                   es_br_target;
    logic [`BPU_TO_DS_BUS_WD-1:0]  es_bpu_bus;
    logic                          ds_valid;
    logic [31:0]                   ds_pc;
    logic                          flush_exc;

    logic [`BRESULT_WD-1:0]        BResult;
    logic                          br_flush;
    logic                          ds_kill;
    logic                          br_redirect_valid;
    logic [31:0]                   br_redirect_pc;
    logic [CNT_WIDTH-1:0]          branch_cnt;
    logic [CNT_WIDTH-1:0]          mispred_cnt;

    modport master (
        output es_go, es_pc, es_is_branch, es_br_taken, es_br_target, es_bpu_bus,
               ds_valid, ds_pc, flush_exc,
        input  BResult, br_flush, ds_kill, br_redirect_valid, br_redirect_pc,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  es_go, es_pc, es_is_branch, es_br_taken, es_br_target, es_bpu_bus,
               ds_valid, ds_pc, flush_exc,
        output BResult, br_flush, ds_kill, br_redirect_valid, br_redirect_pc,
               branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/br_stat_counter.sv
// Wrapping statistics counter: increments by one on en, visible the next
// cycle, wraps at 2^CNT_WIDTH; never stalls.
module br_stat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/global_defines.vh
// Bus widths, field offsets and 2-bit counter encodings shared by the
// branch predictor and the EX-stage branch resolve unit.
`ifndef GLOBAL_DEFINES_VH
`define GLOBAL_DEFINES_VH

`define BPU_TO_DS_BUS_WD   36
`define BPU_RET_ADDR_LSB   0
`define BPU_VALID_BIT      32
`define BPU_COUNT_LSB      33
`define BPU_TAKEN_BIT      35

`define BRESULT_WD         68
`define BRES_TARGET_LSB    0
`define BRES_TAKEN_BIT     32
`define BRES_IS_BRANCH_BIT 33
`define BRES_COUNT_LSB     34
`define BRES_PC_LSB        36

`define CNT_S_TAKEN        2'b00
`define CNT_W_TAKEN        2'b01
`define CNT_WN_TAKEN       2'b10
`define CNT_SN_TAKEN       2'b11

`endif

// File: rtl/branch_resolve_unit.sv
// Checks resolved branches against their prediction, emits the registered BResult strobe and
// a one-cycle fetch redirect once the delay slot sits in decode; outputs 1 cycle after the event, no backpressure.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter bit STATS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  brif
);

    bpu_bus_t    bpu;
    state_t      state_q, state_d;
    logic [31:0] dslot_pc_q, dslot_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    bresult_t    bresult_q, bresult_d;
    logic        br_flush_q, br_flush_d;

    logic        pred_taken;
    logic        mispred;
    logic        right_path;
    logic        resolve;
    logic        stat_en;
    logic [31:0] dslot_new;
    logic [31:0] correct_pc;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    assign bpu        = bpu_bus_t'(brif.es_bpu_bus);
    assign pred_taken = bpu.valid & bpu.is_taken;
    assign mispred    = (pred_taken != brif.es_br_taken) |
                        (pred_taken & brif.es_br_taken & (bpu.ret_addr != brif.es_br_target));
    assign dslot_new  = pc_plus(brif.es_pc, 32'd4);
    assign correct_pc = brif.es_br_taken ? brif.es_br_target : pc_plus(brif.es_pc, 32'd8);

    // Once a mispredict is pending, only the delay slot itself is still on the right path.
    assign right_path = (state_q == IDLE) | (brif.es_pc == dslot_pc_q);
    assign resolve    = brif.es_go & brif.es_is_branch & right_path;
    assign stat_en    = resolve & ~brif.flush_exc;

    always_comb begin
        state_d    = state_q;
        dslot_pc_d = dslot_pc_q;
        pend_pc_d  = pend_pc_q;
        if (brif.flush_exc) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (resolve && mispred) begin
                        dslot_pc_d = dslot_new;
                        pend_pc_d  = correct_pc;
                        state_d    = (brif.ds_valid && (brif.ds_pc == dslot_new)) ? REDIRECT : WAIT_DS;
                    end
                end
                WAIT_DS: begin
                    if (brif.ds_valid && (brif.ds_pc == dslot_pc_q)) begin
                        state_d = REDIRECT;
                    end
                end
                REDIRECT: state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        br_flush_d    = (state_d == REDIRECT);
        redirect_pc_d = br_flush_d ? pend_pc_d : redirect_pc_q;
        bresult_d     = '0;
        if (stat_en) begin
            bresult_d.pc        = brif.es_pc;
            bresult_d.old_count = bpu.valid ? bpu.count : CNT_DEFAULT;
            bresult_d.is_branch = 1'b1;
            bresult_d.taken     = brif.es_br_taken;
            bresult_d.target    = brif.es_br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            dslot_pc_q    <= '0;
            pend_pc_q     <= '0;
            redirect_pc_q <= '0;
            bresult_q     <= '0;
            br_flush_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            dslot_pc_q    <= dslot_pc_d;
            pend_pc_q     <= pend_pc_d;
            redirect_pc_q <= redirect_pc_d;
            bresult_q     <= bresult_d;
            br_flush_q    <= br_flush_d;
        end
    end

    generate
        if (STATS_EN) begin : g_stats
            br_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch_cnt (
                .clk   (clk),
                .reset (reset),
                .en    (stat_en),
                .cnt   (branch_cnt)
            );
            br_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mispred_cnt (
                .clk   (clk),
                .reset (reset),
                .en    (stat_en & mispred),
                .cnt   (mispred_cnt)
            );
        end else begin : g_no_stats
            assign branch_cnt  = '0;
            assign mispred_cnt = '0;
        end
    endgenerate

    assign brif.BResult           = bresult_q;
    assign brif.br_flush          = br_flush_q;
    assign brif.br_redirect_valid = br_flush_q;
    assign brif.br_redirect_pc    = redirect_pc_q;
    assign brif.ds_kill           = (state_q == REDIRECT) & brif.ds_valid & (brif.ds_pc != dslot_pc_q);
    assign brif.branch_cnt        = branch_cnt;
    assign brif.mispred_cnt       = mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed test-plan scenarios plus random traffic,
// every cycle compared against a transaction-level model of the redirect rules.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.CNT_WIDTH(CW)) brif ();

    branch_resolve_unit #(.CNT_WIDTH(CW), .STATS_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .brif  (brif.slave)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: an outstanding mispredict waiting for its delay slot, and
    // whether the current cycle is the redirect cycle.
    bresult_t      m_bres      = '0;
    logic [CW-1:0] m_bcnt      = '0;
    logic [CW-1:0] m_mcnt      = '0;
    logic [31:0]   m_rpc       = '0;
    logic [31:0]   m_last_dslot = '0;
    logic [31:0]   m_pend_tgt  = '0;
    bit            m_pend      = 1'b0;
    bit            m_redirect  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bpu_bus_t    b;
        logic        rp, r, pt, mis, next_redirect;
        logic [31:0] cpc;
        b = brif.es_bpu_bus;
        if (reset) begin
            m_bres = '0; m_bcnt = '0; m_mcnt = '0; m_rpc = '0;
            m_pend = 1'b0; m_redirect = 1'b0;
        end else begin
            rp  = (!m_pend && !m_redirect) || (brif.es_pc == m_last_dslot);
            r   = brif.es_go && brif.es_is_branch && rp;
            pt  = b.valid && b.is_taken;
            mis = (pt != brif.es_br_taken) || (pt && brif.es_br_taken && (b.ret_addr != brif.es_br_target));
            cpc = brif.es_br_taken ? brif.es_br_target : brif.es_pc + 32'd8;
            m_bres = '0;
            if (r && !brif.flush_exc) begin
                m_bres.pc        = brif.es_pc;
                m_bres.old_count = b.valid ? b.count : 2'b10;
                m_bres.is_branch = 1'b1;
                m_bres.taken     = brif.es_br_taken;
                m_bres.target    = brif.es_br_target;
                m_bcnt = m_bcnt + 1'b1;
                if (mis) m_mcnt = m_mcnt + 1'b1;
            end
            next_redirect = 1'b0;
            if (brif.flush_exc) begin
                m_pend = 1'b0;
            end else if (m_redirect) begin
                next_redirect = 1'b0;
            end else if (m_pend) begin
                if (brif.ds_valid && brif.ds_pc == m_last_dslot) begin
                    next_redirect = 1'b1;
                    m_pend = 1'b0;
                    m_rpc = m_pend_tgt;
                end
            end else if (r && mis) begin
                m_last_dslot = brif.es_pc + 32'd4;
                if (brif.ds_valid && brif.ds_pc == m_last_dslot) begin
                    next_redirect = 1'b1;
                    m_rpc = cpc;
                end else begin
                    m_pend = 1'b1;
                    m_pend_tgt = cpc;
                end
            end
            m_redirect = next_redirect;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("bresult", brif.BResult, m_bres);
            chk("br_flush", brif.br_flush, m_redirect);
            chk("br_redirect_valid", brif.br_redirect_valid, m_redirect);
            chk("br_redirect_pc", brif.br_redirect_pc, m_rpc);
            chk("ds_kill", brif.ds_kill,
                m_redirect && brif.ds_valid && (brif.ds_pc != m_last_dslot));
            chk("branch_cnt", brif.branch_cnt, m_bcnt);
            chk("mispred_cnt", brif.mispred_cnt, m_mcnt);
        end
    end

    task automatic clr();
        brif.es_go = 1'b0; brif.es_pc = '0; brif.es_is_branch = 1'b0;
        brif.es_br_taken = 1'b0; brif.es_br_target = '0; brif.es_bpu_bus = '0;
        brif.ds_valid = 1'b0; brif.ds_pc = '0; brif.flush_exc = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic p_valid, input logic p_taken, input logic [1:0] p_cnt,
                      input logic [31:0] p_ret);
        bpu_bus_t b;
        b.is_taken = p_taken; b.count = p_cnt; b.valid = p_valid; b.ret_addr = p_ret;
        brif.es_go = 1'b1; brif.es_is_branch = 1'b1; brif.es_pc = pc;
        brif.es_br_taken = tk; brif.es_br_target = tgt; brif.es_bpu_bus = b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bres"}, brif.BResult, '0);
        chk({tag, "_flush"}, brif.br_flush, 1'b0);
        chk({tag, "_rvalid"}, brif.br_redirect_valid, 1'b0);
        chk({tag, "_rpc"}, brif.br_redirect_pc, '0);
        chk({tag, "_dskill"}, brif.ds_kill, 1'b0);
        chk({tag, "_bcnt"}, brif.branch_cnt, '0);
        chk({tag, "_mcnt"}, brif.mispred_cnt, '0);
    endtask

    initial begin
        bit sel_dslot;
        clr();
        reset = 1'b1;
        step(); step();
        chk_all_zero("reset");
        reset = 1'b0;
        cmp_en = 1'b1;

        // Correct prediction
        br(32'hBFC00040, 1'b1, 32'hBFC00100, 1'b1, 1'b1, 2'b00, 32'hBFC00100);
        step();
        chk("t1_bres", brif.BResult, {32'hBFC00040, 2'b00, 1'b1, 1'b1, 32'hBFC00100});
        chk("t1_flush", brif.br_flush, 1'b0);
        chk("t1_bcnt", brif.branch_cnt, 4'd1);
        chk("t1_mcnt", brif.mispred_cnt, 4'd0);
        clr(); step();
        chk("t1_strobe_end", brif.BResult, '0);

        // Direction mispredict, delay slot already in decode
        br(32'h1000, 1'b1, 32'h2000, 1'b0, 1'b0, 2'b00, 32'h0);
        brif.ds_valid = 1'b1; brif.ds_pc = 32'h1004;
        step();
        clr(); brif.ds_valid = 1'b1; brif.ds_pc = 32'h1004; #1;
        chk("t2_flush", brif.br_flush, 1'b1);
        chk("t2_rvalid", brif.br_redirect_valid, 1'b1);
        chk("t2_rpc", brif.br_redirect_pc, 32'h2000);
        chk("t2_dskill", brif.ds_kill, 1'b0);
        chk("t2_oldcnt", brif.BResult[35:34], 2'b10);
        chk("t2_mcnt", brif.mispred_cnt, 4'd1);
        clr(); step();
        chk("t2_flush_end", brif.br_flush, 1'b0);

        // Not-taken mispredict, delay slot arrives late
        br(32'h3000, 1'b0, 32'h3500, 1'b1, 1'b1, 2'b01, 32'h3500);
        step();
        clr(); step();
        chk("t3_wait1", brif.br_flush, 1'b0);
        step();
        chk("t3_wait2", brif.br_flush, 1'b0);
        brif.ds_valid = 1'b1; brif.ds_pc = 32'h3004;
        step();
        chk("t3_flush", brif.br_flush, 1'b1);
        chk("t3_rpc", brif.br_redirect_pc, 32'h3008);
        clr(); step();
        chk("t3_flush_end", brif.br_flush, 1'b0);

        // Target mismatch, wrong-path decode at flush cycle
        br(32'h3F00, 1'b1, 32'h4800, 1'b1, 1'b1, 2'b00, 32'h4000);
        brif.ds_valid = 1'b1; brif.ds_pc = 32'h3F04;
        step();
        clr(); brif.ds_valid = 1'b1; brif.ds_pc = 32'h4008; #1;
        chk("t4_flush", brif.br_flush, 1'b1);
        chk("t4_rpc", brif.br_redirect_pc, 32'h4800);
        chk("t4_dskill", brif.ds_kill, 1'b1);
        clr(); step();

        // Exception flush while waiting for the delay slot
        br(32'h5000, 1'b1, 32'h5800, 1'b0, 1'b0, 2'b00, 32'h0);
        step();
        clr(); brif.flush_exc = 1'b1; step();
        chk("t5_noflush0", brif.br_flush, 1'b0);
        clr(); brif.ds_valid = 1'b1; brif.ds_pc = 32'h5004; step();
        chk("t5_noflush1", brif.br_flush, 1'b0);
        step();
        chk("t5_noflush2", brif.br_flush, 1'b0);
        br(32'h5000, 1'b1, 32'h5800, 1'b0, 1'b0, 2'b00, 32'h0);
        brif.ds_valid = 1'b0;
        step();
        br(32'h5010, 1'b1, 32'h6000, 1'b0, 1'b0, 2'b00, 32'h0);
        step();
        chk("t5_wrongpath_bres", brif.BResult, '0);
        chk("t5_wrongpath_bcnt", brif.branch_cnt, 4'd6);
        chk("t5_wrongpath_mcnt", brif.mispred_cnt, 4'd5);
        clr(); brif.flush_exc = 1'b1; step();
        chk("t5_noflush3", brif.br_flush, 1'b0);
        clr(); step();

        // Reset while waiting for the delay slot
        br(32'h6000, 1'b1, 32'h6800, 1'b0, 1'b0, 2'b00, 32'h0);
        step();
        clr(); reset = 1'b1; step();
        chk_all_zero("midreset");
        reset = 1'b0; brif.ds_valid = 1'b1; brif.ds_pc = 32'h6004; step();
        chk("t6_noflush", brif.br_flush, 1'b0);
        clr(); step();

        // Counter wrap at 2^4
        for (int i = 0; i < 16; i++) begin
            br(32'h7000 + 32'(i * 8), 1'b0, 32'h0, 1'b1, 1'b0, 2'b11, 32'h0);
            step();
            if (i == 14) chk("wrap_15", brif.branch_cnt, 4'd15);
        end
        clr(); step();
        chk("wrap_0", brif.branch_cnt, 4'd0);
        chk("wrap_mcnt", brif.mispred_cnt, 4'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bpu_bus_t b;
            int dsel;
            clr();
            reset = ($urandom_range(0, 199) == 0);
            brif.flush_exc = ($urandom_range(0, 39) == 0);
            brif.es_go = ($urandom_range(0, 3) != 0);
            sel_dslot = (m_pend || m_redirect) && ($urandom_range(0, 2) == 0);
            brif.es_pc = sel_dslot ? m_last_dslot : 32'h1000 + 32'($urandom_range(0, 15) * 4);
            brif.es_is_branch = $urandom_range(0, 1);
            if ((m_pend || m_redirect) && brif.es_pc == m_last_dslot) brif.es_is_branch = 1'b0;
            brif.es_br_taken = $urandom_range(0, 1);
            brif.es_br_target = 32'h2000 + 32'($urandom_range(0, 3) * 4);
            b.valid = ($urandom_range(0, 3) != 0);
            b.is_taken = $urandom_range(0, 1);
            b.count = 2'($urandom_range(0, 3));
            b.ret_addr = $urandom_range(0, 1) ? brif.es_br_target
                                              : 32'h2000 + 32'($urandom_range(0, 3) * 4);
            brif.es_bpu_bus = b;
            brif.ds_valid = $urandom_range(0, 1);
            dsel = $urandom_range(0, 2);
            brif.ds_pc = (dsel == 0) ? brif.es_pc + 32'd4 :
                         (dsel == 1) ? m_last_dslot : 32'h1000 + 32'($urandom_range(0, 16) * 4);
            step();
        end
        reset = 1'b0;
        clr(); step(); step();
        @(negedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage counterpart of the branch predictor. Compares each resolved branch or jump against the prediction it carried from decode, and emits the predictor update bus (BResult). On a misprediction it drives a fetch redirect and flush, but only after the MIPS delay slot is safely in decode. Sits between the EX-stage branch compare logic and the predictor/fetch stage.

Parameters:
CNT_WIDTH, 32, width of the branch and mispredict statistics counters
STATS_EN, 1, 0 ties both counters to zero

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
es_go  in  1  EX instruction leaves EX this cycle (es_valid & es_ready_go & ms_allowin)
es_pc  in  32  PC of the EX instruction
es_is_branch  in  1  EX instruction is a branch or jump
es_br_taken  in  1  actual outcome
es_br_target  in  32  actual target
es_bpu_bus  in  `BPU_TO_DS_BUS_WD  prediction carried from decode: {is_taken, count[1:0], valid, ret_addr[31:0]}
ds_valid  in  1  decode holds a valid instruction
ds_pc  in  32  decode PC
flush_exc  in  1  exception/eret flush, highest priority
BResult  out  `BRESULT_WD  {pc[31:0], old_count[1:0], is_branch, taken, target[31:0]}
br_flush  out  1  one-cycle pulse: kill fetch and pre-fetch
ds_kill  out  1  kill decode instruction (wrong path), only with br_flush
br_redirect_valid  out  1  equals br_flush
br_redirect_pc  out  32  correct next fetch PC
branch_cnt  out  CNT_WIDTH  resolved right-path branches
mispred_cnt  out  CNT_WIDTH  mispredicted branches

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Resolve event R = es_go & es_is_branch & right_path. right_path = (state==IDLE) | (es_pc == dslot_pc). Wrong-path branches produce no update, no count, no redirect.
- pred_taken = bpu.valid & bpu.is_taken. mispred = (pred_taken != es_br_taken) | (pred_taken & es_br_taken & bpu.ret_addr != es_br_target).
- correct_pc = es_br_taken ? es_br_target : es_pc + 8 (32-bit wrap).
- BResult is registered. The cycle after R it carries {es_pc, bpu.count, 1, es_br_taken, es_br_target}. In every other cycle it is all zeros, so is_branch is a one-cycle write strobe. If bpu.valid = 0, old_count = 2'b10 (weak not-taken).
- FSM (3 states):
  - IDLE: on R & mispred, latch dslot_pc = es_pc+4 and pend_pc = correct_pc. If ds_valid & ds_pc == es_pc+4 in the same cycle, go to REDIRECT; else go to WAIT_DS.
  - WAIT_DS: when ds_valid & ds_pc == dslot_pc, go to REDIRECT.
  - REDIRECT: registered outputs br_flush = br_redirect_valid = 1 and br_redirect_pc = pend_pc for exactly this one cycle. ds_kill = ds_valid & ds_pc != dslot_pc. Next state is IDLE.
- Latency: a mispredict resolved at cycle N with the delay slot present gives the flush at N+1. If the delay slot arrives at cycle M, the flush is at M+1.
- Outside REDIRECT, br_flush, ds_kill and br_redirect_valid are 0 and br_redirect_pc holds its last value.
- flush_exc in any state: state goes to IDLE, pending redirect is discarded, and br_flush is 0 next cycle. A BResult already registered still completes its pulse. If R and flush_exc coincide, BResult is suppressed.
- A delay-slot instruction resolving while the FSM is in WAIT_DS or REDIRECT is right-path and counted. A delay-slot branch is illegal; behaviour is undefined, with no protection required.
- Counters: branch_cnt += 1 on R and mispred_cnt += 1 on R & mispred. Both wrap at 2^CNT_WIDTH, update in the cycle after R, and hold while flush_exc is high.
- reset mid-WAIT_DS: return to IDLE with no flush pulse.

Decomposition:
- `BRESULT_WD, `BPU_TO_DS_BUS_WD, the bus field offsets and the counter encodings (W/S/WN/SN Taken) go in global_defines.vh, shared with the predictor.
- One sub-module: br_stat_counter (parameterised CNT_WIDTH wrap counter with enable), instantiated twice.

Test Plan:
- Correct prediction: bpu valid/taken, ret_addr = 0xBFC00100; es_pc = 0xBFC00040, taken to 0xBFC00100 -> next cycle BResult.is_branch = 1, target 0xBFC00100; no br_flush; branch_cnt = 1, mispred_cnt = 0.
- Direction mispredict with delay slot present: bpu.valid = 0, es_pc = 0x1000 taken to 0x2000, ds_pc = 0x1004 -> at N+1 br_flush = 1, br_redirect_pc = 0x2000, ds_kill = 0, BResult.old_count = 2'b10; mispred_cnt = 1.
- Not-taken mispredict with delay slot late: pred taken, actual not-taken at es_pc = 0x3000, ds empty for 3 cycles then ds_pc = 0x3004 -> br_flush exactly 1 cycle after arrival, br_redirect_pc = 0x3008.
- Target mismatch: pred taken to 0x4000, actual taken to 0x4800 -> redirect 0x4800. A wrong-path ds_pc = 0x4008 at the flush cycle -> ds_kill = 1.
- flush_exc in WAIT_DS -> no br_flush ever. Then a wrong-path branch at es_pc = 0x5010 resolves before flush_exc -> no BResult strobe and no count change.
- Counter wrap with CNT_WIDTH = 4: 16 resolved branches -> branch_cnt returns to 0. Reset asserted mid-run -> all outputs 0 the next cycle.
